key_filter: RTL and testbench



---
 rtl/key_filter_if.sv | 24 ++
 rtl/key_filter.sv | 131 +++++++++++++
 tb/tb_key_filter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/key_filter_if.sv
// Key conditioner signal bundle: raw active-low pins in, debounced level and event pulses out.
interface key_filter_if;
  logic [1:0] key_in;
  logic [1:0] key_state;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_filter.sv
// Two-channel push-button conditioner: synchronise, debounce and emit press/release/long pulses.
// Each key runs its own FSM and counter; nothing is shared between channels.
module key_filter #(
  parameter int CNT_MAX  = 999_999,
  parameter int LONG_MAX = 49_999_999
) (
  input  logic         clk,
  input  logic         rst_n,
  key_filter_if.slave  kif
);

  localparam int CW = $clog2(LONG_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX_C  = CW'(CNT_MAX);
  localparam logic [CW-1:0] LONG_MAX_C = CW'(LONG_MAX);
  localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_F = 2'd1,
    DOWN    = 2'd2,
    REL_F   = 2'd3
  } state_t;

  logic [1:0] s1_r;
  logic [1:0] s2_r;

  // Two-flop synchroniser on the raw pins; idles released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 2'b11;
      s2_r <= 2'b11;
    end else begin
      s1_r <= kif.key_in;
      s2_r <= s1_r;
    end
  end

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_key
      state_t        state_r;
      logic [CW-1:0] cnt_r;
      logic          long_done_r;
      logic          level_r;
      logic          press_r;
      logic          release_r;
      logic          long_r;

      // Per-key debounce FSM; pulses default low so each lasts exactly one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_r     <= IDLE;
          cnt_r       <= ZERO_C;
          long_done_r <= 1'b0;
          level_r     <= 1'b1;
          press_r     <= 1'b0;
          release_r   <= 1'b0;
          long_r      <= 1'b0;
        end else begin
          press_r   <= 1'b0;
          release_r <= 1'b0;
          long_r    <= 1'b0;
          case (state_r)
            IDLE: begin
              level_r <= 1'b1;
              cnt_r   <= ZERO_C;
              if (!s2_r[k]) begin
                state_r <= PRESS_F;
              end
            end
            PRESS_F: begin
              if (s2_r[k]) begin
                state_r <= IDLE;
                cnt_r   <= ZERO_C;
              end else if (cnt_r == CNT_MAX_C) begin
                state_r <= DOWN;
                cnt_r   <= ZERO_C;
                level_r <= 1'b0;
                press_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + ONE_C;
              end
            end
            DOWN: begin
              level_r <= 1'b0;
              if (s2_r[k]) begin
                state_r <= REL_F;
                cnt_r   <= ZERO_C;
              end else if ((cnt_r == LONG_MAX_C) && !long_done_r) begin
                long_r      <= 1'b1;
                long_done_r <= 1'b1;
              end else if (!long_done_r) begin
                cnt_r <= cnt_r + ONE_C;
              end else begin
                cnt_r <= cnt_r;
              end
            end
            REL_F: begin
              // long_done survives a bounce back to DOWN so key_long cannot re-fire.
              if (!s2_r[k]) begin
                state_r <= DOWN;
                cnt_r   <= ZERO_C;
              end else if (cnt_r == CNT_MAX_C) begin
                state_r     <= IDLE;
                cnt_r       <= ZERO_C;
                level_r     <= 1'b1;
                release_r   <= 1'b1;
                long_done_r <= 1'b0;
              end else begin
                cnt_r <= cnt_r + ONE_C;
              end
            end
            default: begin
              state_r     <= IDLE;
              cnt_r       <= ZERO_C;
              long_done_r <= 1'b0;
              level_r     <= 1'b1;
            end
          endcase
        end
      end
    end
  endgenerate

  assign kif.key_state   = {g_key[1].level_r,   g_key[0].level_r};
  assign kif.key_press   = {g_key[1].press_r,   g_key[0].press_r};
  assign kif.key_release = {g_key[1].release_r, g_key[0].release_r};
  assign kif.key_long    = {g_key[1].long_r,    g_key[0].long_r};

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter (CNT_MAX=9, LONG_MAX=29) with an event scoreboard.
module tb_key_filter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_filter_if kif();

  key_filter #(
    .CNT_MAX  (9),
    .LONG_MAX (29)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Event encoding: {cycle, kind (0 press, 1 release, 2 long), key}
  typedef logic [63:0] ev_t;
  ev_t sb[$];

  function automatic ev_t ev(input int c, input int kind, input int k);
    return {32'(c), 16'(kind), 16'(k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive key_in at a falling edge; c0 is the cycle index of the first sampling edge.
  task automatic drive(input logic [1:0] v, output int c0);
    @(negedge clk);
    kif.key_in = v;
    c0 = cyc + 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"},   64'(kif.key_state),   64'(2'b11));
    check({tag, "_press"},   64'(kif.key_press),   64'(2'b00));
    check({tag, "_release"}, 64'(kif.key_release), 64'(2'b00));
    check({tag, "_long"},    64'(kif.key_long),    64'(2'b00));
  endtask

  // Every observed pulse must match the next expected event exactly.
  always @(negedge clk) begin
    logic [1:0] v;
    for (int kind = 0; kind < 3; kind++) begin
      case (kind)
        0:       v = kif.key_press;
        1:       v = kif.key_release;
        default: v = kif.key_long;
      endcase
      for (int k = 0; k < 2; k++) begin
        if (v[k]) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", ev(cyc, kind, k), {64{1'b1}});
          end else begin
            ev_t e;
            e = sb.pop_front();
            check("pulse", ev(cyc, kind, k), e);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    kif.key_in = 2'b11;
    rst_n = 1'b0;
    step(3);
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check("post_reset_state", 64'(kif.key_state), 64'(2'b11));

    // Clean press held past the long-press threshold
    drive(2'b10, c0);
    sb.push_back(ev(c0 + 12, 0, 0));
    sb.push_back(ev(c0 + 42, 2, 0));
    wait_cyc(c0 + 11);
    check("press_pre_state", 64'(kif.key_state), 64'(2'b11));
    wait_cyc(c0 + 12);
    check("press_state", 64'(kif.key_state), 64'(2'b10));
    wait_cyc(c0 + 50);
    check("held_state", 64'(kif.key_state), 64'(2'b10));
    check("clean_sb_empty", 64'(sb.size()), 64'(0));

    // Release with a bounce: high 4, low 2, then high for good
    drive(2'b11, c1);
    step(3);
    drive(2'b10, c1);
    step(1);
    drive(2'b11, c1);
    sb.push_back(ev(c1 + 12, 1, 0));
    wait_cyc(c1 + 11);
    check("rel_pre_state", 64'(kif.key_state), 64'(2'b10));
    wait_cyc(c1 + 12);
    check("rel_state", 64'(kif.key_state), 64'(2'b11));
    step(20);
    check("rel_sb_empty", 64'(sb.size()), 64'(0));

    // Bounce rejection: low 5, high 3, four times
    for (int r = 0; r < 4; r++) begin
      drive(2'b10, c1);
      step(4);
      drive(2'b11, c1);
      step(2);
    end
    step(30);
    check("bounce_state", 64'(kif.key_state), 64'(2'b11));
    check("bounce_sb_empty", 64'(sb.size()), 64'(0));

    // Both keys pressed on the same cycle, released before long-press
    drive(2'b00, c0);
    sb.push_back(ev(c0 + 12, 0, 0));
    sb.push_back(ev(c0 + 12, 0, 1));
    wait_cyc(c0 + 11);
    check("sim_pre_state", 64'(kif.key_state), 64'(2'b11));
    wait_cyc(c0 + 12);
    check("sim_state", 64'(kif.key_state), 64'(2'b00));
    check("sim_press", 64'(kif.key_press), 64'(2'b11));
    wait_cyc(c0 + 19);
    drive(2'b11, c1);
    sb.push_back(ev(c1 + 12, 1, 0));
    sb.push_back(ev(c1 + 12, 1, 1));
    wait_cyc(c1 + 12);
    check("sim_rel_state", 64'(kif.key_state), 64'(2'b11));
    step(20);
    check("sim_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while key 0 is mid-filter (cnt = 5)
    drive(2'b10, c0);
    wait_cyc(c0 + 7);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_filter");
    step(3);
    check("rst_hold_state", 64'(kif.key_state), 64'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;
    c1 = cyc + 1;
    sb.push_back(ev(c1 + 12, 0, 0));
    wait_cyc(c1 + 11);
    check("redeb_pre_state", 64'(kif.key_state), 64'(2'b11));
    wait_cyc(c1 + 12);
    check("redeb_state", 64'(kif.key_state), 64'(2'b10));

    // Reset while key 0 is DOWN: level must snap back to released
    step(5);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_down");
    @(negedge clk);
    rst_n = 1'b1;
    c1 = cyc + 1;
    sb.push_back(ev(c1 + 12, 0, 0));
    wait_cyc(c1 + 12);
    check("redeb2_state", 64'(kif.key_state), 64'(2'b10));
    drive(2'b11, c1);
    sb.push_back(ev(c1 + 12, 1, 0));
    wait_cyc(c1 + 12);
    check("redeb2_rel_state", 64'(kif.key_state), 64'(2'b11));
    step(15);
    check("rst_sb_empty", 64'(sb.size()), 64'(0));

    // Short press: no long-press event
    drive(2'b10, c0);
    sb.push_back(ev(c0 + 12, 0, 0));
    step(14);
    drive(2'b11, c1);
    sb.push_back(ev(c1 + 12, 1, 0));
    wait_cyc(c1 + 40);
    check("short_state", 64'(kif.key_state), 64'(2'b11));
    check("short_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
